mandelbrot_multilane: RTL and testbench
=======================================

// Module: mandelbrot_multilane
// PURPOSE
//  Multi-lane successor to the single-engine Mandelbrot FSM. Sweeps a WIDTH x HEIGHT raster, farms
//  pixels to LANES mandelbrot_alu instances, and emits escape counts in strict raster order on a
//  valid/ready pixel stream. Sits between the register/config front end and the display/stream
//  back end; generalises lane count, counter width, output depth and counter shift.
// PARAMETERS
//  BITWIDTH  10   fixed-point width of c/z (two's complement)
//  CTRWIDTH  10   iteration counter width
//  LANES     2    parallel ALU lanes (>=1)
//  OUTBITS   4    pix_data width
//  WIDTH     320  pixels per row
//  HEIGHT    240  rows per frame
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  async active-low reset
//  run         in   1                  start frame (sampled when idle)
//  abort       in   1                  synchronous frame abort
//  running     out  1                  frame in progress
//  finished    out  1                  idle / frame complete (level)
//  frame_done  out  1                  1-cycle pulse after last pixel accepted
//  max_ctr     in   CTRWIDTH           iteration limit
//  ctr_shift   in   $clog2(CTRWIDTH)   right shift applied to count before truncation
//  scaling     in   7                  step = scaling+1 per pixel/row
//  cr_offset   in   BITWIDTH           c real at x=0
//  ci_offset   in   BITWIDTH           c imag at y=0
//  pix_valid   out  1                  pixel result valid
//  pix_ready   in   1                  sink accepts
//  pix_data    out  OUTBITS            (ctr >> ctr_shift)[OUTBITS-1:0]
//  pix_x       out  $clog2(WIDTH)      column of pix_data
//  pix_y       out  $clog2(HEIGHT)     row of pix_data
// BEHAVIOUR
//  Reset: running=0, finished=1, frame_done=0, pix_valid=0, pix_data/pix_x/pix_y=0; lanes IDLE.
//  Start: run=1 while finished=1 -> next cycle running=1, finished=0; dispatcher at (0,0),
//   cr=cr_offset, ci=ci_offset. run while running: ignored. run and abort same cycle: abort wins.
//  Dispatch: round-robin pointer d; pixel k goes to lane k mod LANES, only when that lane is IDLE.
//   Per dispatch cr += step; at x=WIDTH-1: cr=cr_offset, ci += step, y++. Wrap mod 2^BITWIDTH.
//   Stops after (WIDTH-1, HEIGHT-1); a lane may remain unused in the final round.
//  Lane FSM: IDLE -> ITER (z=0, ctr=0, first_iteration=1) -> DONE.
//   ITER: each alu completion = finished 1->0 edge. On completion: escape if
//   size | overflowed | ctr==max_ctr -> latch ctr, go DONE; else z<=out_z, ctr++,
//   overflowed<=overflow, restart alu. max_ctr=0 -> ctr 0 after one alu pass.
//  Output: pointer o, same round-robin order. pix_valid=1 while lane o is DONE. Transfer on
//   pix_valid & pix_ready: lane o -> IDLE, o advances. pix_data/x/y stable while valid & !ready.
//   Output path adds 1 registered cycle after DONE.
//  End: final transfer -> next cycle frame_done=1 (1 cycle), running=0, finished=1.
//  Abort: next cycle all lanes IDLE, pix_valid=0, running=0, finished=1, no frame_done;
//   in-flight results discarded; next run restarts at (0,0).
//  Config inputs are used live; the sink must hold them stable for the whole frame.
// CONFIGURATION
//  JULIA_MODE_EN defined: adds inputs julia(1), jr(BITWIDTH), ji(BITWIDTH); julia sampled at run.
//   julia=1: c={jr,ji} for every pixel, z0 = pixel coordinate, first_iteration=0.
//   julia=0, or macro undefined: ports absent, Mandelbrot only (c = pixel, z0=0).
// TESTING
//  1 LANES=2, WIDTH=4, HEIGHT=2, max_ctr=0, pix_ready=1 -> 8 pixels, (x,y) raster order,
//    data 0, one frame_done.
//  2 cr_offset=ci_offset=0, scaling=0, max_ctr=5, ctr_shift=0 -> pixel (0,0) data=5;
//    ctr_shift=1 -> 2.
//  3 pix_ready=0 for 20 cycles mid-frame -> pix_valid held, data/x/y stable, no pixel lost
//    or reordered.
//  4 abort at pixel 3 -> next cycle pix_valid=0, running=0, finished=1; run -> first pixel (0,0).
//  5 run pulsed while running -> no effect; run+abort same cycle from idle -> stays finished=1.
//  6 JULIA_MODE_EN, julia=1, jr=ji=0, max_ctr=7 -> origin pixel data=7; far pixel escapes <7.

Source files
------------

// File: rtl/mandelbrot_multilane.sv
// Multi-lane Mandelbrot raster engine: round-robin dispatch to LANES iterators, in-order pixel stream.
// Optional Julia mode is enabled by defining JULIA_MODE_EN (adds julia, jr, ji inputs).
module mandelbrot_multilane #(
    parameter int unsigned BITWIDTH = 10,
    parameter int unsigned CTRWIDTH = 10,
    parameter int unsigned LANES    = 2,
    parameter int unsigned OUTBITS  = 4,
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          abort,
    output logic                          running,
    output logic                          finished,
    output logic                          frame_done,
    input  logic [CTRWIDTH-1:0]           max_ctr,
    input  logic [$clog2(CTRWIDTH)-1:0]   ctr_shift,
    input  logic [6:0]                    scaling,
    input  logic [BITWIDTH-1:0]           cr_offset,
    input  logic [BITWIDTH-1:0]           ci_offset,
`ifdef JULIA_MODE_EN
    input  logic                          julia,
    input  logic [BITWIDTH-1:0]           jr,
    input  logic [BITWIDTH-1:0]           ji,
`endif
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [OUTBITS-1:0]            pix_data,
    output logic [$clog2(WIDTH)-1:0]      pix_x,
    output logic [$clog2(HEIGHT)-1:0]     pix_y
);
    // Fixed point: 3 integer bits (incl. sign), remaining bits fraction, so |z|^2 > 4 is the bailout.
    localparam int unsigned FRAC = BITWIDTH - 3;
    localparam int unsigned WW   = 2 * BITWIDTH + 2;
    localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned XW   = $clog2(WIDTH);
    localparam int unsigned YW   = $clog2(HEIGHT);
    localparam logic signed [WW-1:0] EscLim = WW'(1) << (2 * FRAC + 2);

    typedef enum logic [1:0] {StIdle, StIter, StDone} lane_st_e;

    typedef struct packed {
        logic signed [BITWIDTH-1:0] zr;
        logic signed [BITWIDTH-1:0] zi;
        logic                       ovf;
        logic                       size;
    } alu_res_t;

    function automatic alu_res_t alu(input logic signed [BITWIDTH-1:0] zr, input logic signed [BITWIDTH-1:0] zi,
                                     input logic signed [BITWIDTH-1:0] cr, input logic signed [BITWIDTH-1:0] ci,
                                     input logic first);
        logic signed [WW-1:0] rr, ii, ri, nr, ni, hr, hi;
        alu_res_t r;
        rr = WW'(zr) * WW'(zr);
        ii = WW'(zi) * WW'(zi);
        ri = WW'(zr) * WW'(zi);
        nr = first ? WW'(cr) : ((rr - ii) >>> FRAC) + WW'(cr);
        ni = first ? WW'(ci) : ((ri <<< 1) >>> FRAC) + WW'(ci);
        hr = nr >>> (BITWIDTH - 1);
        hi = ni >>> (BITWIDTH - 1);
        r.zr   = nr[BITWIDTH-1:0];
        r.zi   = ni[BITWIDTH-1:0];
        r.ovf  = !((hr == '0) || (hr == '1)) || !((hi == '0) || (hi == '1));
        r.size = (rr + ii) > EscLim;
        return r;
    endfunction

    function automatic logic [LW-1:0] lane_inc(input logic [LW-1:0] p);
        return (p == LW'(LANES - 1)) ? '0 : p + LW'(1);
    endfunction

    lane_st_e                   st_q    [LANES];
    logic signed [BITWIDTH-1:0] zr_q    [LANES];
    logic signed [BITWIDTH-1:0] zi_q    [LANES];
    logic signed [BITWIDTH-1:0] cr_q    [LANES];
    logic signed [BITWIDTH-1:0] ci_q    [LANES];
    logic [CTRWIDTH-1:0]        ctr_q   [LANES];
    logic                       first_q [LANES];
    logic                       ovf_q   [LANES];
    logic [XW-1:0]              px_q    [LANES];
    logic [YW-1:0]              py_q    [LANES];
    alu_res_t                   res     [LANES];
    logic                       esc     [LANES];

    logic [LW-1:0]       d_q, o_q, o_nxt;
    logic [XW-1:0]       dx_q;
    logic [YW-1:0]       dy_q;
    logic [BITWIDTH-1:0] dcr_q, dci_q, step;
    logic                disp_act_q, start, dispatch, transfer, last_pix;
    logic signed [BITWIDTH-1:0] ld_zr, ld_zi, ld_cr, ld_ci;
    logic                ld_first;
    logic [CTRWIDTH-1:0] shifted;
`ifdef JULIA_MODE_EN
    logic                julia_q;
`endif

    assign finished = ~running;
    assign step     = {{(BITWIDTH - 7){1'b0}}, scaling} + BITWIDTH'(1);
    assign start    = run & ~running & ~abort;
    assign dispatch = running & disp_act_q & (st_q[d_q] == StIdle);
    assign transfer = pix_valid & pix_ready;
    assign last_pix = (pix_x == XW'(WIDTH - 1)) && (pix_y == YW'(HEIGHT - 1));
    assign o_nxt    = transfer ? lane_inc(o_q) : o_q;
    assign shifted  = ctr_q[o_nxt] >> ctr_shift;

    always_comb begin
        ld_cr    = dcr_q;
        ld_ci    = dci_q;
        ld_zr    = '0;
        ld_zi    = '0;
        ld_first = 1'b1;
`ifdef JULIA_MODE_EN
        if (julia_q) begin
            ld_cr    = jr;
            ld_ci    = ji;
            ld_zr    = dcr_q;
            ld_zi    = dci_q;
            ld_first = 1'b0;
        end
`endif
        for (int l = 0; l < LANES; l++) begin
            res[l] = alu(zr_q[l], zi_q[l], cr_q[l], ci_q[l], first_q[l]);
            esc[l] = res[l].size | ovf_q[l] | (ctr_q[l] == max_ctr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running    <= 1'b0;
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            d_q        <= '0;
            o_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            dcr_q      <= '0;
            dci_q      <= '0;
            disp_act_q <= 1'b0;
`ifdef JULIA_MODE_EN
            julia_q    <= 1'b0;
`endif
            for (int l = 0; l < LANES; l++) begin
                st_q[l]    <= StIdle;
                zr_q[l]    <= '0;
                zi_q[l]    <= '0;
                cr_q[l]    <= '0;
                ci_q[l]    <= '0;
                ctr_q[l]   <= '0;
                first_q[l] <= 1'b0;
                ovf_q[l]   <= 1'b0;
                px_q[l]    <= '0;
                py_q[l]    <= '0;
            end
        end else if (abort) begin
            // In-flight work is dropped; the next run restarts the raster from scratch.
            running    <= 1'b0;
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            disp_act_q <= 1'b0;
            for (int l = 0; l < LANES; l++) st_q[l] <= StIdle;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                running    <= 1'b1;
                d_q        <= '0;
                o_q        <= '0;
                dx_q       <= '0;
                dy_q       <= '0;
                dcr_q      <= cr_offset;
                dci_q      <= ci_offset;
                disp_act_q <= 1'b1;
`ifdef JULIA_MODE_EN
                julia_q    <= julia;
`endif
            end
            if (dispatch) begin
                d_q <= lane_inc(d_q);
                if (dx_q == XW'(WIDTH - 1)) begin
                    dx_q  <= '0;
                    dcr_q <= cr_offset;
                    dci_q <= dci_q + step;
                    dy_q  <= dy_q + YW'(1);
                    if (dy_q == YW'(HEIGHT - 1)) disp_act_q <= 1'b0;
                end else begin
                    dx_q  <= dx_q + XW'(1);
                    dcr_q <= dcr_q + step;
                end
            end
            for (int l = 0; l < LANES; l++) begin
                case (st_q[l])
                    StIdle: begin
                        if (dispatch && (d_q == LW'(l))) begin
                            st_q[l]    <= StIter;
                            zr_q[l]    <= ld_zr;
                            zi_q[l]    <= ld_zi;
                            cr_q[l]    <= ld_cr;
                            ci_q[l]    <= ld_ci;
                            first_q[l] <= ld_first;
                            ovf_q[l]   <= 1'b0;
                            ctr_q[l]   <= '0;
                            px_q[l]    <= dx_q;
                            py_q[l]    <= dy_q;
                        end
                    end
                    StIter: begin
                        if (esc[l]) begin
                            st_q[l] <= StDone;
                        end else begin
                            zr_q[l]    <= res[l].zr;
                            zi_q[l]    <= res[l].zi;
                            ovf_q[l]   <= res[l].ovf;
                            first_q[l] <= 1'b0;
                            ctr_q[l]   <= ctr_q[l] + CTRWIDTH'(1);
                        end
                    end
                    StDone: begin
                        if (transfer && (o_q == LW'(l))) st_q[l] <= StIdle;
                    end
                    default: st_q[l] <= StIdle;
                endcase
            end
            if (transfer) o_q <= o_nxt;
            // With one lane the lane being drained is also o_nxt; it must not look valid again.
            pix_valid <= running && (st_q[o_nxt] == StDone) && !(transfer && (o_nxt == o_q));
            if (st_q[o_nxt] == StDone) begin
                pix_data <= shifted[OUTBITS-1:0];
                pix_x    <= px_q[o_nxt];
                pix_y    <= py_q[o_nxt];
            end
            if (transfer && last_pix) begin
                running    <= 1'b0;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_multilane.sv
// Directed bench for mandelbrot_multilane: a per-pixel escape-count model feeds an expected queue
// that a single negedge compare process drains in raster order.
module tb_mandelbrot_multilane;
    localparam int BW = 10;
    localparam int CW = 10;
    localparam int L  = 2;
    localparam int OB = 4;
    localparam int W  = 4;
    localparam int H  = 2;

    logic clk, rst_n, run, abort, running, finished, frame_done;
    logic [CW-1:0] max_ctr;
    logic [3:0]    ctr_shift;
    logic [6:0]    scaling;
    logic [BW-1:0] cr_offset, ci_offset;
    logic          pix_valid, pix_ready;
    logic [OB-1:0] pix_data;
    logic [1:0]    pix_x;
    logic [0:0]    pix_y;
`ifdef JULIA_MODE_EN
    logic          julia;
    logic [BW-1:0] jr, ji;
`endif

    mandelbrot_multilane #(
        .BITWIDTH(BW), .CTRWIDTH(CW), .LANES(L), .OUTBITS(OB), .WIDTH(W), .HEIGHT(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
        .running(running), .finished(finished), .frame_done(frame_done),
        .max_ctr(max_ctr), .ctr_shift(ctr_shift), .scaling(scaling),
        .cr_offset(cr_offset), .ci_offset(ci_offset),
`ifdef JULIA_MODE_EN
        .julia(julia), .jr(jr), .ji(ji),
`endif
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    pix_t expq[$];
    int   nvec = 0, nerr = 0;
    int   rx_count = 0, fd_count = 0;
    int   first_d, first_x, first_y, last_d;
    int   fd_exp = 0;
    bit   checking = 0;
    bit   jul_mode = 0;
    int   jr_v = 0, ji_v = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        int r;
        r = v & ((1 << BW) - 1);
        if (r >= (1 << (BW - 1))) r -= (1 << BW);
        return r;
    endfunction

    // z <- z^2 + c in Q3.(BW-3); stop on |z|^2 > 4, a previous overflow, or ctr reaching the limit.
    function automatic int esc_count(input int cr, input int ci, input int zr0, input int zi0,
                                     input bit first0, input int maxc);
        int ctr, nr, ni, zr, zi, lim, f;
        bit ovf, first;
        ctr = 0; ovf = 0; zr = zr0; zi = zi0; first = first0;
        f = BW - 3;
        lim = 1 << (BW - 1);
        for (int it = 0; it < (1 << CW); it++) begin
            if ((zr * zr + zi * zi > (1 << (2 * f + 2))) || ovf || ctr == maxc) return ctr;
            if (first) begin
                nr = cr; ni = ci;
            end else begin
                nr = ((zr * zr - zi * zi) >>> f) + cr;
                ni = ((2 * zr * zi) >>> f) + ci;
            end
            ovf = (nr >= lim) || (nr < -lim) || (ni >= lim) || (ni < -lim);
            zr = wrap(nr); zi = wrap(ni); first = 0;
            ctr++;
        end
        return ctr;
    endfunction

    task automatic cfg(input int cro, input int cio, input int scal, input int maxc, input int shift);
        int step, pcr, pci, cnt;
        pix_t p;
        cr_offset = BW'(cro);
        ci_offset = BW'(cio);
        scaling   = 7'(scal);
        max_ctr   = CW'(maxc);
        ctr_shift = 4'(shift);
        expq.delete();
        rx_count = 0;
        fd_count = 0;
        step = scal + 1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                pcr = wrap(cro + x * step);
                pci = wrap(cio + y * step);
                if (jul_mode) cnt = esc_count(jr_v, ji_v, pcr, pci, 1'b0, maxc);
                else          cnt = esc_count(pcr, pci, 0, 0, 1'b1, maxc);
                p.x = x; p.y = y; p.d = (cnt >> shift) & ((1 << OB) - 1);
                expq.push_back(p);
            end
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string name);
        int c;
        c = 0;
        while (rx_count < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(rx_count >= n), 1);
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!(finished && expq.size() == 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(c < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("frame_done", int'(frame_done), fd_exp);
            if (frame_done) fd_count++;
            fd_exp = 0;
            if (pix_valid) begin
                if (expq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL pix_extra: got pixel (%0d,%0d), expected none", pix_x, pix_y);
                end else begin
                    chk("pix_x", int'(pix_x), expq[0].x);
                    chk("pix_y", int'(pix_y), expq[0].y);
                    chk("pix_data", int'(pix_data), expq[0].d);
                    if (pix_ready) begin
                        if (expq[0].x == W - 1 && expq[0].y == H - 1) fd_exp = 1;
                        if (rx_count == 0) begin
                            first_d = int'(pix_data);
                            first_x = int'(pix_x);
                            first_y = int'(pix_y);
                        end
                        last_d = int'(pix_data);
                        void'(expq.pop_front());
                        rx_count++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_rx;
        bit seen;
        rst_n = 1'b0; run = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        cr_offset = '0; ci_offset = '0; scaling = '0; max_ctr = '0; ctr_shift = '0;
`ifdef JULIA_MODE_EN
        julia = 1'b0; jr = '0; ji = '0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_running", int'(running), 0);
        chk("rst_finished", int'(finished), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_pix_xy", int'({pix_x, pix_y}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        checking = 1'b1;

        chk("model_c0_max5", esc_count(0, 0, 0, 0, 1'b1, 5), 5);
        chk("model_far_c", esc_count(300, 0, 0, 0, 1'b1, 7), 1);
        chk("model_half", esc_count(64, 0, 0, 0, 1'b1, 10), 5);

        // 1: max_ctr=0, every pixel is 0, full raster, single frame_done
        cfg(0, 0, 3, 0, 0);
        start_frame();
        wait_done("t1_timeout");
        chk("t1_pixels", rx_count, 8);
        chk("t1_frame_done_count", fd_count, 1);
        chk("t1_running", int'(running), 0);
        chk("t1_finished", int'(finished), 1);

        // 2: c=0 never escapes, count saturates at max_ctr, shifted view
        cfg(0, 0, 0, 5, 0);
        start_frame();
        wait_done("t2a_timeout");
        chk("t2a_first_data", first_d, 5);
        cfg(0, 0, 0, 5, 1);
        start_frame();
        wait_done("t2b_timeout");
        chk("t2b_first_data", first_d, 2);
        cfg(300, 0, 0, 7, 0);
        start_frame();
        wait_done("t2c_timeout");
        chk("t2c_first_data", first_d, 1);

        // 3: sink stall mid-frame
        cfg(-256, -128, 63, 15, 0);
        start_frame();
        wait_rx(2, "t3_reach2");
        @(posedge clk); #1 pix_ready = 1'b0;
        stall_rx = rx_count;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (seen) chk("t3_valid_held", int'(pix_valid), 1);
            if (pix_valid) seen = 1;
        end
        chk("t3_valid_seen", int'(seen), 1);
        chk("t3_no_accept", rx_count, stall_rx);
        @(posedge clk); #1 pix_ready = 1'b1;
        wait_done("t3_timeout");
        chk("t3_pixels", rx_count, 8);
        chk("t3_frame_done_count", fd_count, 1);

        // 4: abort after three pixels, then a clean restart
        cfg(-256, -128, 63, 15, 0);
        start_frame();
        wait_rx(3, "t4_reach3");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_valid", int'(pix_valid), 0);
        chk("t4_abort_running", int'(running), 0);
        chk("t4_abort_finished", int'(finished), 1);
        expq.delete();
        repeat (10) @(negedge clk);
        chk("t4_no_frame_done", fd_count, 0);
        cfg(-256, -128, 63, 15, 0);
        start_frame();
        wait_done("t4_timeout");
        chk("t4_restart_x", first_x, 0);
        chk("t4_restart_y", first_y, 0);
        chk("t4_pixels", rx_count, 8);

        // 5: run while running is ignored; run+abort from idle stays idle
        cfg(-192, 64, 20, 9, 1);
        start_frame();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        wait_done("t5_timeout");
        chk("t5_pixels", rx_count, 8);
        chk("t5_frame_done_count", fd_count, 1);
        repeat (5) @(negedge clk);
        chk("t5_still_idle", int'(running), 0);
        @(posedge clk); #1 run = 1'b1; abort = 1'b1;
        @(posedge clk); #1 run = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("t5_run_abort_finished", int'(finished), 1);
        chk("t5_run_abort_running", int'(running), 0);

`ifdef JULIA_MODE_EN
        // 6: Julia with c=0: origin never escapes, far corner escapes at once
        jul_mode = 1; jr_v = 0; ji_v = 0;
        julia = 1'b1; jr = '0; ji = '0;
        cfg(0, 0, 127, 7, 0);
        start_frame();
        wait_done("t6_timeout");
        chk("t6_origin_data", first_d, 7);
        chk("t6_far_data", last_d, 0);
        jul_mode = 0;
        julia = 1'b0;
`endif

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
